// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle 64-bit data-memory responder on a req/ack handshake
// with configurable wait states and alignment / range fault detection.
module dmem_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int MEM_WORDS   = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [63:0] address,
   input  logic [63:0] wdata,
   output logic        ack,
   output logic [63:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int DATA_W = 64;
   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   // Returns {fault, word_index}; any byte offset or bit above the index field faults.
   function automatic logic [IDX_W:0] addr_decode(input logic [63:0] a);
      logic fault;
      fault = (a[2:0] != 3'd0) || (a[63:IDX_W+3] != '0);
      return {fault, a[IDX_W+2:3]};
   endfunction

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                accept;
   logic                enter_ack;
   logic [IDX_W:0]      dec_in;

   logic                we_p0;
   logic                fault_p0;
   logic [IDX_W-1:0]    idx_p0;
   logic [DATA_W-1:0]   wdata_p0;

   logic                acc_we;
   logic                acc_fault;
   logic [IDX_W-1:0]    acc_idx;
   logic [DATA_W-1:0]   acc_wdata;

   logic [DATA_W-1:0]   mem [MEM_WORDS];

   assign dec_in = addr_decode(address);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt = ACK;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // With zero wait states ACK is entered on the acceptance edge itself, so the
   // access must use the live request fields rather than the captured copies.
   assign acc_we    = (state == IDLE) ? we                   : we_p0;
   assign acc_fault = (state == IDLE) ? dec_in[IDX_W]        : fault_p0;
   assign acc_idx   = (state == IDLE) ? dec_in[IDX_W-1:0]    : idx_p0;
   assign acc_wdata = (state == IDLE) ? wdata                : wdata_p0;

   assign enter_ack = (state_nxt == ACK) && (state != ACK);

   assign ack  = (state == ACK);
   assign busy = (state != IDLE);

   // Stage p0: request capture on acceptance
   always_ff @(posedge clock) begin
      if (accept) begin
         we_p0    <= we;
         fault_p0 <= dec_in[IDX_W];
         idx_p0   <= dec_in[IDX_W-1:0];
         wdata_p0 <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err   <= enter_ack && acc_fault;
         if (enter_ack) begin
            if (acc_fault) begin
               rdata <= '0;
            end else if (!acc_we) begin
               rdata <= mem[acc_idx];
            end
         end
      end
   end

   // Stage p1: store commit on the edge entering ACK; an aborting reset suppresses it
   always_ff @(posedge clock) begin
      if (!reset && enter_ack && acc_we && !acc_fault) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule
